// File: rtl/bus_memory_responder.sv
// Word-addressed RAM acting as a bus responder with a fixed number of wait states.
// Optional macro BUS_RESPONDER_ALIGN_CHECK_EN: misaligned addresses return an error.
module bus_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

    state_t             state, state_nxt;
    logic [3:0]         count, count_nxt;
    logic               lat_write;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic [3:0]         lat_wstrb;
    logic [31:0]        mem [DEPTH_WORDS];

    logic               accept;
    logic               enter_resp;
    logic               acc_write;
    logic [31:0]        acc_addr;
    logic [31:0]        acc_wdata;
    logic [3:0]         acc_wstrb;
    logic [32:0]        offset;
    logic               in_range;
    logic               misalign;
    logic               acc_err;
    logic [IDX_W-1:0]   acc_idx;
    logic               mem_we;

    assign req_ready  = (state == IDLE) && !reset;
    assign resp_valid = (state == RESPOND);
    assign accept     = req_valid && req_ready;

    // With zero wait states the access resolves on the acceptance edge, so use live inputs.
    assign acc_write = (state == IDLE) ? req_write : lat_write;
    assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    assign acc_wstrb = (state == IDLE) ? req_wstrb : lat_wstrb;

    assign offset   = {1'b0, acc_addr} - {1'b0, BASE_ADDR};
    assign in_range = ({1'b0, acc_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, acc_addr} < LIMIT);
    assign acc_idx  = IDX_W'(offset >> 2);

`ifdef BUS_RESPONDER_ALIGN_CHECK_EN
    assign misalign = (acc_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign acc_err    = !in_range || misalign;
    assign enter_resp = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                        ((state == WAIT) && (count == 4'd0));
    assign mem_we     = enter_resp && acc_write && !acc_err && !reset;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESPOND;
                    end else begin
                        state_nxt = WAIT;
                        count_nxt = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (count == 4'd0) state_nxt = RESPOND;
                else               count_nxt = count - 4'd1;
            end
            RESPOND: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 4'd0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (enter_resp) begin
                resp_rdata <= (!acc_write && !acc_err) ? mem[acc_idx] : 32'd0;
                resp_error <= acc_err;
            end else if ((state == RESPOND) && resp_ready) begin
                resp_rdata <= 32'd0;
                resp_error <= 1'b0;
            end
        end
    end

    // Request fields are captured at acceptance; the master may change them afterwards.
    always_ff @(posedge clock) begin
        if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_wstrb <= req_wstrb;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_bus_memory_responder.sv
// Scoreboard bench for bus_memory_responder: one instance with one wait state, one with none.
module tb_bus_memory_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, resp_valid, resp_error;
    logic [31:0] resp_rdata;

    logic        r0_req_valid = 1'b0, r0_req_write = 1'b0, r0_resp_ready = 1'b1;
    logic [31:0] r0_req_addr = '0, r0_req_wdata = '0;
    logic [3:0]  r0_req_wstrb = '0;
    logic        r0_req_ready, r0_resp_valid, r0_resp_error;
    logic [31:0] r0_resp_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q1[$];
    exp_t q0[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic pv1 = 1'b0, pv0 = 1'b0;

    bus_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_error(resp_error)
    );

    bus_memory_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(r0_req_valid), .req_ready(r0_req_ready), .req_write(r0_req_write),
        .req_addr(r0_req_addr), .req_wdata(r0_req_wdata), .req_wstrb(r0_req_wstrb),
        .resp_valid(r0_resp_valid), .resp_ready(r0_resp_ready),
        .resp_rdata(r0_resp_rdata), .resp_error(r0_resp_error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (resp_valid && !pv1) begin
            if (q1.size() == 0) chk("w1_unexpected_resp", 32'd1, 32'd0);
            else                chk("w1_latency", 32'(cyc - q1[0].acc), 32'd1);
        end
        if (resp_valid && resp_ready && q1.size() > 0) begin
            e = q1.pop_front();
            chk("w1_rdata", resp_rdata, e.rdata);
            chk("w1_error", {31'd0, resp_error}, {31'd0, e.err});
        end
        pv1 = resp_valid;
    end

    always @(negedge clock) begin
        exp_t e;
        if (r0_resp_valid && !pv0) begin
            if (q0.size() == 0) chk("w0_unexpected_resp", 32'd1, 32'd0);
            else                chk("w0_latency", 32'(cyc - q0[0].acc), 32'd0);
        end
        if (r0_resp_valid && r0_resp_ready && q0.size() > 0) begin
            e = q0.pop_front();
            chk("w0_rdata", r0_resp_rdata, e.rdata);
            chk("w0_error", {31'd0, r0_resp_error}, {31'd0, e.err});
        end
        pv0 = r0_resp_valid;
    end

    task automatic issue(input bit sel, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input bit push, output int acc);
        logic rs;
        bit   ok;
        ok  = 1'b0;
        acc = 0;
        if (sel) begin
            req_valid = 1'b1; req_write = wr; req_addr = addr;
            req_wdata = wdata; req_wstrb = wstrb;
        end else begin
            r0_req_valid = 1'b1; r0_req_write = wr; r0_req_addr = addr;
            r0_req_wdata = wdata; r0_req_wstrb = wstrb;
        end
        for (int t = 0; t < 100; t++) begin
            rs = sel ? req_ready : r0_req_ready;
            @(posedge clock);
            #1;
            if (rs) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        acc = cyc;
        if (push) begin
            if (sel) q1.push_back('{rdata: exp_rdata, err: exp_err, acc: acc});
            else     q0.push_back('{rdata: exp_rdata, err: exp_err, acc: acc});
        end
        if (sel) req_valid = 1'b0;
        else     r0_req_valid = 1'b0;
    endtask

    task automatic drain(input bit sel);
        for (int i = 0; i < 60; i++) begin
            if ((sel ? q1.size() : q0.size()) == 0) break;
            @(posedge clock);
            #1;
        end
        chk("drain", 32'(sel ? q1.size() : q0.size()), 32'd0);
    endtask

    initial begin
        int a, b;
        logic [31:0] exp22_d;
        logic        exp22_e;

        // Reset state
        @(negedge clock);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_r0_req_ready", {31'd0, r0_req_ready}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Full write, read back, partial write, no-op write
        issue(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, 1, a); drain(1);
        issue(1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, 1, a); drain(1);
        issue(1, 1, 32'h10, 32'h000000AA, 4'b0001, 32'h0, 0, 1, a); drain(1);
        issue(1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0, 1, a); drain(1);
        issue(1, 1, 32'h10, 32'h12345678, 4'h0, 32'h0, 0, 1, a); drain(1);
        issue(1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0, 1, a); drain(1);

        // Range boundaries
        issue(1, 1, 32'hFFC, 32'hCAFEF00D, 4'hF, 32'h0, 0, 1, a); drain(1);
        issue(1, 0, 32'hFFC, 32'h0, 4'h0, 32'hCAFEF00D, 0, 1, a); drain(1);
        issue(1, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 1, 1, a); drain(1);
        issue(1, 0, 32'hFFFF_FFFC, 32'h0, 4'h0, 32'h0, 1, 1, a); drain(1);
        issue(1, 1, 32'h1000, 32'h55555555, 4'hF, 32'h0, 1, 1, a); drain(1);

        // Backpressure: response held while a new request waits
        resp_ready = 1'b0;
        issue(1, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEAA, 0, 1, a);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hFFC;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (resp_valid) break;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_resp_rdata", resp_rdata, 32'hDEADBEAA);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        chk("release_req_ready", {31'd0, req_ready}, 32'd1);
        chk("release_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clock); #1;
        q1.push_back('{rdata: 32'hCAFEF00D, err: 1'b0, acc: cyc});
        req_valid = 1'b0;
        chk("accepted_next_cycle", {31'd0, req_ready}, 32'd0);
        drain(1);

        // Zero wait states: one transfer per two cycles
        issue(0, 1, 32'h0, 32'hA0A0A0A0, 4'hF, 32'h0, 0, 1, a); drain(0);
        issue(0, 1, 32'h4, 32'hB0B0B0B0, 4'hF, 32'h0, 0, 1, a); drain(0);
        issue(0, 0, 32'h0, 32'h0, 4'h0, 32'hA0A0A0A0, 0, 1, a);
        issue(0, 0, 32'h4, 32'h0, 4'h0, 32'hB0B0B0B0, 0, 1, b);
        chk("w0_throughput", 32'(b - a), 32'd2);
        drain(0);

        // Reset while waiting aborts the write
        issue(1, 1, 32'h20, 32'h11111111, 4'hF, 32'h0, 0, 1, a); drain(1);
        issue(1, 1, 32'h20, 32'h22222222, 4'hF, 32'h0, 0, 0, a);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clock);
        chk("postrst_no_resp", {31'd0, resp_valid}, 32'd0);
        issue(1, 0, 32'h20, 32'h0, 4'h0, 32'h11111111, 0, 1, a); drain(1);

        // Misaligned read
`ifdef BUS_RESPONDER_ALIGN_CHECK_EN
        exp22_d = 32'h0; exp22_e = 1'b1;
`else
        exp22_d = 32'h11111111; exp22_e = 1'b0;
`endif
        issue(1, 0, 32'h22, 32'h0, 4'h0, exp22_d, exp22_e, 1, a); drain(1);

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
